// File: rtl/extractor_sign.sv
// extractor_sign: walks an MSB-first video bit stream under flag/skip control entries
// and packs the flagged bits into sign bytes.
module extractor_sign (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic [7:0] vid_in,
    input  logic       vid_empty,
    input  logic [7:0] cnt_in,
    input  logic       cnt_empty,
    input  logic       flush,
    input  logic       out_afull,
    output logic       vid_rd,
    output logic       cnt_rd,
    output logic [7:0] sign_out,
    output logic       sign_wr,
    output logic [3:0] sign_cnt,
    output logic       last_sign_out
);
    localparam logic [1:0] FILL = 2'd0, EXTRACT = 2'd1, SKIP = 2'd2, HOLD = 2'd3;
    logic [1:0] state, prev, op, state_n;
    logic [7:0] vid_q, ent_q, byte_c, ent_c, acc, acc_n;
    logic       vid_v, vid_p, ent_v, ent_p, wr_q;
    logic [3:0] rem, rem_n, k, k_n;
    logic [2:0] ptr;
    logic [6:0] carry, carry_n, skip, resid;
    logic       en, byte_ok, ent_ok, apply, discard, settle, take_byte, extract, bit_x, full, dump;
    assign en = clk_en & ~out_afull;
    assign op = state == HOLD ? prev : state;
    // a read issued last cycle makes FIFO data usable directly, without waiting for the register
    assign byte_ok = vid_v | vid_p;
    assign ent_ok = ent_v | ent_p;
    assign byte_c = vid_p ? vid_in : vid_q;
    assign ent_c = ent_p ? cnt_in : ent_q;
    assign skip = ent_c[6:0];
    assign ptr = rem[2:0] - 3'd1;
    assign bit_x = byte_c[ptr];
    assign apply = en & (op != SKIP) & byte_ok & ent_ok;
    assign discard = en & (op == SKIP) & (carry >= 7'd8) & byte_ok;
    assign settle = en & (op == SKIP) & (carry < 7'd8);
    assign take_byte = discard | (apply & (skip >= {3'b0, rem}));
    assign resid = apply ? skip - {3'b0, rem} : carry - 7'd8;
    assign extract = apply & ent_c[7];
    assign acc_n = extract ? {acc[6:0], bit_x} : acc;
    assign k_n = k + {3'b0, extract};
    assign full = k_n == 4'd8;
    assign dump = full | (en & flush & (k_n != 4'd0));
    assign vid_rd = rst_n & en & ~vid_empty & (~byte_ok | take_byte);
    assign cnt_rd = rst_n & en & ~cnt_empty & (~ent_ok | apply);
    assign sign_wr = wr_q & en;
    always_comb begin
        rem_n = rem;
        if (apply & ~take_byte)
            rem_n = rem - skip[3:0];
        else if ((apply & (resid < 7'd8)) | settle)
            rem_n = 4'd8 - (settle ? carry[3:0] : resid[3:0]);
        carry_n = (discard | (apply & take_byte & (resid >= 7'd8))) ? resid : carry;
        state_n = !en ? state : apply ? ((take_byte & (resid >= 7'd8)) ? SKIP : EXTRACT) :
                  discard ? SKIP : settle ? EXTRACT : HOLD;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            prev <= FILL;
            vid_q <= '0;
            ent_q <= '0;
            vid_v <= 1'b0;
            vid_p <= 1'b0;
            ent_v <= 1'b0;
            ent_p <= 1'b0;
            rem <= 4'd8;
            carry <= '0;
            acc <= '0;
            k <= '0;
            wr_q <= 1'b0;
            sign_out <= '0;
            sign_cnt <= '0;
            last_sign_out <= 1'b0;
        end else begin
            vid_p <= vid_rd;
            ent_p <= cnt_rd;
            vid_v <= byte_ok & ~take_byte;
            ent_v <= ent_ok & ~apply;
            vid_q <= byte_c;
            ent_q <= ent_c;
            state <= state_n;
            prev <= en ? op : prev;
            rem <= rem_n;
            carry <= carry_n;
            acc <= dump ? 8'd0 : acc_n;
            k <= dump ? 4'd0 : k_n;
            // an emitted byte stays pending while stalled so the strobe is never lost
            wr_q <= dump | (wr_q & ~en);
            if (dump) begin
                sign_out <= acc_n << (4'd8 - k_n);
                sign_cnt <= k_n;
            end
            if (extract) last_sign_out <= bit_x;
        end
    end
endmodule
